// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic MDU_MULT = 1'b0;
  localparam logic MDU_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration on unsigned magnitudes.
// The dividend bits are shifted out of the top of quoIn, and the new quotient bit
// enters at the bottom, so after WIDTH steps quoOut holds the quotient.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] remIn,
  input  logic [WIDTH-1:0] quoIn,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remOut,
  output logic [WIDTH-1:0] quoOut
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Shift the next dividend bit in and trial-subtract; restore the old value on borrow.
  always_comb begin
    shifted = {remIn, quoIn[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    if (trial[WIDTH]) begin
      remOut = shifted[WIDTH-1:0];
      quoOut = {quoIn[WIDTH-2:0], 1'b0};
    end else begin
      remOut = trial[WIDTH-1:0];
      quoOut = {quoIn[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring) unit with HI/LO result registers.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_t       state, stateNext;
  logic [CW-1:0]    count;
  logic             opR;
  logic [WIDTH-1:0] mcand;
  // Booth accumulator: {upper partial product, multiplier, q(-1)}
  logic [2*WIDTH:0] acc;
  logic [2*WIDTH:0] accNext;
  logic [WIDTH:0]   boothUpper, boothMcand, boothSum;
  logic [WIDTH-1:0] remR, quoR, divisor;
  logic [WIDTH-1:0] remStep, quoStep;
  logic [WIDTH-1:0] quoFinal, remFinal;
  logic             negQuo, negRem;
  logic             divByZero, lastIter;

  assign divByZero = (op == MDU_DIV) && (b == '0);
  assign lastIter  = (count == CW'(WIDTH - 1));

  // Booth step: the add/sub is done one bit wider so the -2^(W-1) multiplicand cannot overflow.
  always_comb begin
    boothUpper = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
    boothMcand = {mcand[WIDTH-1], mcand};
    boothSum   = boothUpper;
    case (acc[1:0])
      2'b01:   boothSum = boothUpper + boothMcand;
      2'b10:   boothSum = boothUpper - boothMcand;
      default: boothSum = boothUpper;
    endcase
    accNext = {boothSum, acc[WIDTH:1]};
  end

  mdu_div_step #(.WIDTH(WIDTH)) uDivStep (
    .remIn   (remR),
    .quoIn   (quoR),
    .divisor (divisor),
    .remOut  (remStep),
    .quoOut  (quoStep)
  );

  // Sign correction of the final division step, applied only at commit.
  always_comb begin
    quoFinal = negQuo ? -quoStep : quoStep;
    remFinal = negRem ? -remStep : remStep;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state and status outputs.
  always_comb begin
    stateNext = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) stateNext = divByZero ? DONE : RUN;
      RUN: begin
        busy = 1'b1;
        if (lastIter) stateNext = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Operand latch, iteration datapath and HI/LO commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      opR      <= 1'b0;
      mcand    <= '0;
      acc      <= '0;
      remR     <= '0;
      quoR     <= '0;
      divisor  <= '0;
      negQuo   <= 1'b0;
      negRem   <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          // Both setups are loaded; only the one matching opR is iterated.
          opR      <= op;
          mcand    <= a;
          acc      <= {{(WIDTH+1){1'b0}}, b, 1'b0};
          remR     <= '0;
          quoR     <= a[WIDTH-1] ? -a : a;
          divisor  <= b[WIDTH-1] ? -b : b;
          negQuo   <= a[WIDTH-1] ^ b[WIDTH-1];
          negRem   <= a[WIDTH-1];
          count    <= '0;
          div_zero <= divByZero;
        end
        RUN: begin
          count <= count + 1'b1;
          if (opR == MDU_MULT) begin
            acc <= accNext;
            if (lastIter) begin
              hi <= accNext[2*WIDTH:WIDTH+1];
              lo <= accNext[WIDTH:1];
            end
          end else begin
            remR <= remStep;
            quoR <= quoStep;
            if (lastIter) begin
              hi <= remFinal;
              lo <= quoFinal;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a, b;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int lat, busyCnt, doneCnt;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one operation and follow it to completion plus a few idle cycles.
  // disturb: scramble a/b after acceptance and pulse start at cycles 5 and 20.
  task automatic runOp(input logic o, input logic [31:0] x, input logic [31:0] y, input bit disturb,
                       output int latency, output int nBusy, output int nDone);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    if (disturb) begin a = ~x; b = y + 32'h5; end
    latency = 0; nBusy = 0; nDone = 0;
    while (done !== 1'b1 && latency < 100) begin
      if (busy === 1'b1) nBusy++;
      if (disturb && (latency == 5 || latency == 20)) begin
        start = 1'b1; a = $urandom; b = $urandom; op = ~o;
      end else begin
        start = 1'b0;
      end
      tick();
      latency++;
    end
    start = 1'b0;
    if (busy === 1'b1) nBusy++;
    if (done === 1'b1) nDone++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done === 1'b1) nDone++;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    tick();
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dz",   32'(div_zero), 32'd0);
    check("rst_hi",   hi, 32'd0);
    check("rst_lo",   lo, 32'd0);

    // 7 * -3 = -21
    runOp(1'b0, 32'd7, 32'hFFFFFFFD, 1'b0, lat, busyCnt, doneCnt);
    check("m1_lat",  32'(lat), 32'd32);
    check("m1_busy", 32'(busyCnt), 32'd33);
    check("m1_hi",   hi, 32'hFFFFFFFF);
    check("m1_lo",   lo, 32'hFFFFFFEB);
    check("m1_idle", 32'(busy), 32'd0);

    // most-negative squared
    runOp(1'b0, 32'h80000000, 32'h80000000, 1'b0, lat, busyCnt, doneCnt);
    check("m2_hi", hi, 32'h40000000);
    check("m2_lo", lo, 32'h00000000);

    // -1 * -1
    runOp(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat, busyCnt, doneCnt);
    check("m3_hi", hi, 32'd0);
    check("m3_lo", lo, 32'd1);

    // -7 / 2 = -3 rem -1
    runOp(1'b1, 32'hFFFFFFF9, 32'd2, 1'b0, lat, busyCnt, doneCnt);
    check("d1_lat", 32'(lat), 32'd32);
    check("d1_lo",  lo, 32'hFFFFFFFD);
    check("d1_hi",  hi, 32'hFFFFFFFF);
    check("d1_dz",  32'(div_zero), 32'd0);

    // -2^31 / -1 wraps
    runOp(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, lat, busyCnt, doneCnt);
    check("d2_lo", lo, 32'h80000000);
    check("d2_hi", hi, 32'd0);
    check("d2_dz", 32'(div_zero), 32'd0);

    // -100 / 7 = -14 rem -2 ; 100 / -7 = -14 rem 2
    runOp(1'b1, 32'hFFFFFF9C, 32'd7, 1'b0, lat, busyCnt, doneCnt);
    check("d3_lo", lo, 32'hFFFFFFF2);
    check("d3_hi", hi, 32'hFFFFFFFE);
    runOp(1'b1, 32'd100, 32'hFFFFFFF9, 1'b0, lat, busyCnt, doneCnt);
    check("d4_lo", lo, 32'hFFFFFFF2);
    check("d4_hi", hi, 32'd2);

    // 1105 / 32 = 34 rem 17 leaves hi=0x11, lo=0x22
    runOp(1'b1, 32'd1105, 32'd32, 1'b0, lat, busyCnt, doneCnt);
    check("d5_lo", lo, 32'h22);
    check("d5_hi", hi, 32'h11);

    // divide by zero: immediate done, HI/LO untouched
    runOp(1'b1, 32'd5, 32'd0, 1'b0, lat, busyCnt, doneCnt);
    check("dz_lat",  32'(lat), 32'd0);
    check("dz_busy", 32'(busyCnt), 32'd1);
    check("dz_flag", 32'(div_zero), 32'd1);
    check("dz_hi",   hi, 32'h11);
    check("dz_lo",   lo, 32'h22);

    // start pulses while busy and operand churn are ignored
    runOp(1'b0, 32'h12345678, 32'h00000100, 1'b1, lat, busyCnt, doneCnt);
    check("ign_lat",  32'(lat), 32'd32);
    check("ign_done", 32'(doneCnt), 32'd1);
    check("ign_hi",   hi, 32'h00000012);
    check("ign_lo",   lo, 32'h34567800);
    check("ign_dz",   32'(div_zero), 32'd0);

    // reset in the middle of RUN aborts
    op = 1'b0; a = 32'd3; b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_done", 32'(done), 32'd0);
    check("ab_hi",   hi, 32'd0);
    check("ab_lo",   lo, 32'd0);

    // fresh op after abort: 6 * -7 = -42
    runOp(1'b0, 32'd6, 32'hFFFFFFF9, 1'b0, lat, busyCnt, doneCnt);
    check("post_lat", 32'(lat), 32'd32);
    check("post_hi",  hi, 32'hFFFFFFFF);
    check("post_lo",  lo, 32'hFFFFFFD6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Multi-cycle signed multiply/divide unit for the multicycle datapath, downstream of the main control FSM. Control pulses start with an operation code; the unit iterates for 32 cycles while operands flow from regA/regB. It then writes the 64-bit result into internal HI/LO registers and pulses done. Control holds its state until done, then moves HI or LO onto the register-file write path.

Parameters:
WIDTH, 32, operand width; HI/LO are WIDTH bits each; the iteration count equals WIDTH.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high; sampled on rising clk
start  input  1  request; accepted only in IDLE
op  input  1  0 = MULT (signed), 1 = DIV (signed)
a  input  WIDTH  multiplicand / dividend (regA)
b  input  WIDTH  multiplier / divisor (regB)
busy  output  1  high in RUN and DONE
done  output  1  one-cycle completion pulse
div_zero  output  1  DIV with b == 0; valid with done, held until next accepted start
hi  output  WIDTH  MULT: product[63:32]; DIV: remainder
lo  output  WIDTH  MULT: product[31:0]; DIV: quotient

Behaviour:
- Reset (sync, one edge): state = IDLE; busy = done = div_zero = 0; hi = lo = 0; counter and scratch registers = 0. Reset in RUN or DONE aborts the operation and drops it.
- FSM states: IDLE, RUN, DONE.
  - IDLE + start: latch a, b, op; clear div_zero.
    - If op = DIV and b == 0: go to DONE and set div_zero = 1. hi/lo keep their previous values.
    - Otherwise: go to RUN with counter = 0 and perform the sign/magnitude setup.
  - RUN: one iteration per edge; counter increments. On the edge with counter == WIDTH-1, commit the result to hi/lo and go to DONE.
  - DONE: done = 1 for exactly this one cycle; go to IDLE on the next edge unconditionally.
- Latency: the start edge is E0.
  - Normal op: done is high in the cycle after E32, so 32 cycles after acceptance; busy is high for 33 cycles.
  - Divide by zero: done is high in the cycle after E0.
- start while busy is ignored; operands are not re-latched. start held high through DONE is accepted again only once IDLE is reached.
- a and b are don't-care after E0; the unit works only from its latched copies.
- MULT: radix-2 Booth over a 2*WIDTH+1-bit accumulator with arithmetic right shift each iteration. The result is the exact two's-complement 64-bit product.
- DIV: restoring division on operand magnitudes. Quotient sign = sign(a) XOR sign(b); remainder takes the sign of a, with truncation toward zero.
  - Sign correction is applied at commit.
  - -2^31 / -1 gives lo = 0x80000000, hi = 0 (natural wrap), div_zero = 0.
- hi/lo change only at commit (or reset) and are otherwise stable, so control may read them any cycle.

Decomposition:
- Shared package mdu_pkg:
  - state enum mdu_state_t {IDLE, RUN, DONE};
  - op constants MDU_MULT = 1'b0, MDU_DIV = 1'b1;
  - WIDTH default constant.
- Sub-module mdu_div_step: combinational single restoring-division iteration (remainder/quotient in, shifted result out). It is instantiated once inside mult_div_unit. The Booth step stays inline.

Test Plan:
- MULT a=7, b=-3 (0xFFFFFFFD) -> done exactly 32 cycles after the start edge; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high 33 cycles.
- MULT a=b=0x80000000 -> hi=0x40000000, lo=0x00000000; a second MULT 0xFFFFFFFF*0xFFFFFFFF -> hi=0, lo=1.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
- DIV a=5, b=0 after a prior result hi=0x11, lo=0x22 -> done one cycle after start; div_zero=1; hi=0x11, lo=0x22 unchanged; busy high one cycle.
- start pulsed at cycles 5 and 20 during a MULT, with a/b changed after E0 -> result matches the original operands; exactly one done pulse.
- reset asserted at cycle 10 of RUN -> next cycle busy=0, done=0, hi=lo=0; a fresh start afterwards completes normally in 32 cycles.
